// File: rtl/adpll_bringup_sequencer.sv
// -----------------------------------------------------------------------------
// adpll_bringup_sequencer
//
// Purpose:
//   Brings up a network of NODES all-digital PLLs in three stages:
//     1. ACQUIRE: wide-band acquisition with high gains.
//     2. TRACK:   tracking gains against the common reference.
//     3. NETWORK: tracking gains against network references.
//   It then parks in RUN. Each wait state advances once every node has been
//   continuously in lock for LOCK_CYCLES cycles. It drops to FAULT if a wait
//   state lasts TIMEOUT_CYCLES cycles.
//
// Ports:
//   fpga_clk_i      sole clock, rising edge
//   reset_i         synchronous active-high reset
//   start_i         start bring-up from IDLE or FAULT (level)
//   abort_i         return to IDLE from any state (beats start_i)
//   error_i         per-node signed phase error, node n at [n*PDET_WIDTH +: PDET_WIDTH]
//   enable_o        per-node ADPLL enable
//   network_mode_o  0 = common reference, 1 = network references
//   kp_o / ki_o     loop-filter gains
//   locked_o        per-node lock flags
//   state_o         state code (IDLE=0 ACQUIRE=1 TRACK=2 NETWORK=3 RUN=4 FAULT=5)
//   done_o          high in RUN
//   timeout_o       high in FAULT
//
// Configuration macro:
//   SEQ_RELOCK_EN   when defined, a falling locked_o bit in RUN forces a full
//                   re-acquisition (back to ACQUIRE). When undefined, RUN is
//                   held until abort or reset.
// -----------------------------------------------------------------------------
module adpll_bringup_sequencer #(
  parameter int NODES          = 4,
  parameter int PDET_WIDTH     = 5,
  parameter int KP_WIDTH       = 8,
  parameter int KI_WIDTH       = 10,
  parameter int KP_ACQ         = 8,
  parameter int KI_ACQ         = 8,
  parameter int KP_TRK         = 2,
  parameter int KI_TRK         = 1,
  parameter int LOCK_THRESH    = 2,
  parameter int LOCK_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        fpga_clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [NODES*PDET_WIDTH-1:0] error_i,
  output logic [NODES-1:0]            enable_o,
  output logic                        network_mode_o,
  output logic [KP_WIDTH-1:0]         kp_o,
  output logic [KI_WIDTH-1:0]         ki_o,
  output logic [NODES-1:0]            locked_o,
  output logic [2:0]                  state_o,
  output logic                        done_o,
  output logic                        timeout_o
);

  localparam int MW = PDET_WIDTH + 1;                 // magnitude width (holds 2^(PDET_WIDTH-1))
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [MW-1:0]       THRESH_M = MW'(LOCK_THRESH);
  localparam logic [CW-1:0]       CNT_MAX  = CW'(LOCK_CYCLES);
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [KP_WIDTH-1:0] KP_A     = KP_WIDTH'(KP_ACQ);
  localparam logic [KI_WIDTH-1:0] KI_A     = KI_WIDTH'(KI_ACQ);
  localparam logic [KP_WIDTH-1:0] KP_T     = KP_WIDTH'(KP_TRK);
  localparam logic [KI_WIDTH-1:0] KI_T     = KI_WIDTH'(KI_TRK);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQUIRE = 3'd1,
    S_TRACK   = 3'd2,
    S_NETWORK = 3'd3,
    S_RUN     = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tmo_q;
  logic [NODES-1:0]     enable_q;
  logic                 network_q;
  logic [KP_WIDTH-1:0]  kp_q;
  logic [KI_WIDTH-1:0]  ki_q;
  logic                 done_q;
  logic                 timeout_q;

  logic [NODES-1:0]     lock_vec;   // registered per-node lock flags
  logic [NODES-1:0]     lock_stay;  // lock flag each node would have if the state is held
  logic                 state_change;
  logic                 en_d;       // nodes enabled in the next state
  logic                 in_wait;    // current state is a timed wait state
  logic                 tmo_expired;

  assign in_wait      = (state_q == S_ACQUIRE) || (state_q == S_TRACK) ||
                        (state_q == S_NETWORK);
  assign tmo_expired  = in_wait && (tmo_q == TMO_LAST);
  assign state_change = (state_d != state_q);
  assign en_d         = (state_d == S_ACQUIRE) || (state_d == S_TRACK) ||
                        (state_d == S_NETWORK) || (state_d == S_RUN);

  // Next-state logic. Lock completion is tested before timeout, so it wins a tie.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start_i) state_d = S_ACQUIRE;
        S_ACQUIRE: if (&lock_vec) state_d = S_TRACK;
                   else if (tmo_expired) state_d = S_FAULT;
        S_TRACK:   if (&lock_vec) state_d = S_NETWORK;
                   else if (tmo_expired) state_d = S_FAULT;
        S_NETWORK: if (&lock_vec) state_d = S_RUN;
                   else if (tmo_expired) state_d = S_FAULT;
        S_RUN: begin
`ifdef SEQ_RELOCK_EN
          // A falling edge is judged on the held-state update, which avoids a
          // loop through the state-entry clear.
          if (|(lock_vec & ~lock_stay)) state_d = S_ACQUIRE;
`endif
        end
        S_FAULT:   if (start_i) state_d = S_ACQUIRE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Per-node magnitude, in-lock detection and saturating lock counter.
  for (genvar gi = 0; gi < NODES; gi++) begin : g_node
    logic [PDET_WIDTH-1:0] err;
    logic [PDET_WIDTH-1:0] neg;
    logic [MW-1:0]         mag;
    logic                  in_lock;
    logic [CW-1:0]         cnt_q, cnt_upd, cnt_d;
    logic                  locked_q;

    assign err = error_i[gi*PDET_WIDTH +: PDET_WIDTH];
    // Negating the most-negative code yields the same bit pattern. Read as
    // unsigned, that pattern is 2^(PDET_WIDTH-1), which is the required
    // magnitude.
    assign neg     = -err;
    assign mag     = {1'b0, (err[PDET_WIDTH-1] ? neg : err)};
    assign in_lock = (mag <= THRESH_M);

    assign cnt_upd = !in_lock           ? '0      :
                     (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    // On a state entry, or when the node is disabled, prior lock history is
    // no longer valid.
    assign cnt_d   = (state_change || !en_d) ? '0 : cnt_upd;

    assign lock_stay[gi] = (cnt_upd == CNT_MAX);
    assign lock_vec[gi]  = locked_q;

    always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
        cnt_q    <= '0;
        locked_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        locked_q <= (cnt_d == CNT_MAX);
      end
    end
  end

  // State register and outputs. Outputs are decoded from the next state, so
  // they change on the same edge as state_o.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      enable_q  <= '0;
      network_q <= 1'b0;
      kp_q      <= '0;
      ki_q      <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_change || !in_wait) tmo_q <= '0;
      else                          tmo_q <= tmo_q + 1'b1;

      enable_q  <= en_d ? '1 : '0;
      network_q <= 1'b0;
      kp_q      <= '0;
      ki_q      <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_d)
        S_ACQUIRE: begin
          kp_q <= KP_A;
          ki_q <= KI_A;
        end
        S_TRACK: begin
          kp_q <= KP_T;
          ki_q <= KI_T;
        end
        S_NETWORK: begin
          network_q <= 1'b1;
          kp_q      <= KP_T;
          ki_q      <= KI_T;
        end
        S_RUN: begin
          network_q <= 1'b1;
          kp_q      <= KP_T;
          ki_q      <= KI_T;
          done_q    <= 1'b1;
        end
        S_FAULT:   timeout_q <= 1'b1;
        default:   ;
      endcase
    end
  end

  assign state_o        = state_q;
  assign enable_o       = enable_q;
  assign network_mode_o = network_q;
  assign kp_o           = kp_q;
  assign ki_o           = ki_q;
  assign locked_o       = lock_vec;
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adpll_bringup_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adpll_bringup_sequencer
//
// Directed bench for adpll_bringup_sequencer with default parameters.
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at the
// same point. Expected values are hand-derived cycle counts: a wait state with
// clean errors lasts LOCK_CYCLES+1 = 65 edges.
// -----------------------------------------------------------------------------
module tb_adpll_bringup_sequencer;

  logic        clk = 1'b0;
  logic        reset_i, start_i, abort_i;
  logic [19:0] error_i;
  logic [3:0]  enable_o, locked_o;
  logic        network_mode_o, done_o, timeout_o;
  logic [7:0]  kp_o;
  logic [9:0]  ki_o;
  logic [2:0]  state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  adpll_bringup_sequencer dut (
    .fpga_clk_i     (clk),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .error_i        (error_i),
    .enable_o       (enable_o),
    .network_mode_o (network_mode_o),
    .kp_o           (kp_o),
    .ki_o           (ki_o),
    .locked_o       (locked_o),
    .state_o        (state_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_err(input int node, input logic [4:0] val);
    error_i[node*5 +: 5] = val;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".state"},  32'(state_o), 32'd0);
    chk({tag, ".outs"},
        32'({enable_o, network_mode_o, kp_o, ki_o, locked_o, done_o, timeout_o}),
        32'd0);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; error_i = '0;
    tick(2);
    chk_all_zero("reset");
    reset_i = 1'b0;
    tick(1);
    chk("idle_hold", 32'(state_o), 32'd0);

    // ---- Full clean bring-up, then RUN lock-loss behaviour ----
    start_i = 1'b1; tick(1); start_i = 1'b0;
    chk("acq.state", 32'(state_o), 32'd1);
    chk("acq.gains", 32'({kp_o, ki_o}), 32'({8'd8, 10'd8}));
    chk("acq.en",    32'({enable_o, network_mode_o}), 32'b11110);
    tick(64);
    chk("acq.state64",  32'(state_o), 32'd1);
    chk("acq.locked64", 32'(locked_o), 32'hF);
    tick(1);
    chk("trk.state",  32'(state_o), 32'd2);
    chk("trk.gains",  32'({kp_o, ki_o}), 32'({8'd2, 10'd1}));
    chk("trk.locked", 32'(locked_o), 32'd0);
    tick(65);
    chk("net.state", 32'(state_o), 32'd3);
    chk("net.mode",  32'(network_mode_o), 32'd1);
    tick(64);
    chk("net.done_pre", 32'(done_o), 32'd0);
    tick(1);
    chk("run.state", 32'(state_o), 32'd4);
    chk("run.done",  32'(done_o), 32'd1);
    tick(64);
    chk("run.locked", 32'(locked_o), 32'hF);
    set_err(3, 5'd7); tick(1); set_err(3, 5'd0);
`ifdef SEQ_RELOCK_EN
    chk("relock.state", 32'(state_o), 32'd1);
    chk("relock.kp",    32'(kp_o), 32'd8);
`else
    chk("hold.state",  32'(state_o), 32'd4);
    chk("hold.locked", 32'(locked_o), 32'b0111);
    chk("hold.done",   32'(done_o), 32'd1);
`endif
    abort_i = 1'b1; tick(1); abort_i = 1'b0;
    chk_all_zero("abort_run");

    // ---- Magnitude boundaries: -16 out of lock, -2 in lock ----
    set_err(0, 5'b10000);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    tick(64);
    chk("neg16.locked", 32'(locked_o), 32'b1110);
    tick(6);
    chk("neg16.state", 32'(state_o), 32'd1);
    set_err(0, 5'b11110);
    tick(64);
    chk("neg2.locked", 32'(locked_o), 32'hF);
    tick(1);
    chk("neg2.state", 32'(state_o), 32'd2);
    set_err(0, 5'd0);
    abort_i = 1'b1; tick(1); abort_i = 1'b0;

    // ---- TRACK extended by a lock glitch at lock cycle 40 ----
    start_i = 1'b1; tick(1); start_i = 1'b0;
    tick(65);
    chk("glitch.trk", 32'(state_o), 32'd2);
    tick(40);
    set_err(1, 5'd3); tick(1); set_err(1, 5'd0);
    tick(24);
    chk("glitch.e65.state",  32'(state_o), 32'd2);
    chk("glitch.e65.locked", 32'(locked_o), 32'b1101);
    tick(40);
    chk("glitch.e105.state", 32'(state_o), 32'd2);
    chk("glitch.e105.locked", 32'(locked_o), 32'hF);
    tick(1);
    chk("glitch.e106.state", 32'(state_o), 32'd3);

    // ---- Abort mid-NETWORK ----
    tick(10);
    abort_i = 1'b1; tick(1); abort_i = 1'b0;
    chk_all_zero("abort_net");

    // ---- Reset mid-NETWORK, with start_i asserted too ----
    start_i = 1'b1; tick(1); start_i = 1'b0;
    tick(140);
    chk("rst.pre", 32'(state_o), 32'd3);
    reset_i = 1'b1; start_i = 1'b1; tick(1);
    chk_all_zero("rst_net");
    reset_i = 1'b0; start_i = 1'b0;

    // ---- start and abort together in IDLE ----
    start_i = 1'b1; abort_i = 1'b1; tick(1);
    chk_all_zero("start_abort");
    start_i = 1'b0; abort_i = 1'b0;

    // ---- Timeout in ACQUIRE with node 2 at -3, then FAULT exit ----
    set_err(2, 5'b11101);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    tick(4095);
    chk("tmo.pre", 32'(state_o), 32'd1);
    tick(1);
    chk("tmo.state", 32'(state_o), 32'd5);
    chk("tmo.flags", 32'({timeout_o, enable_o, kp_o, ki_o}), 32'({1'b1, 4'd0, 8'd0, 10'd0}));
    tick(3);
    chk("tmo.hold", 32'({state_o, timeout_o}), 32'({3'd5, 1'b1}));
    set_err(2, 5'd0);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    chk("fault_exit", 32'({state_o, timeout_o, kp_o}), 32'({3'd1, 1'b0, 8'd8}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adpll_bringup_sequencer.md
ADPLL_BRINGUP_SEQUENCER -- requirements
Module: adpll_bringup_sequencer

Interface
REQ-001 SHALL have parameter NODES, default 4, number of ADPLL nodes sequenced.
REQ-002 SHALL have parameter PDET_WIDTH, default 5, width of each node phase-error word (two's complement).
REQ-003 SHALL have parameter KP_WIDTH, default 8, proportional gain output width.
REQ-004 SHALL have parameter KI_WIDTH, default 10, integral gain output width.
REQ-005 SHALL have parameters KP_ACQ/KI_ACQ, defaults 8/8, acquisition gains.
REQ-006 SHALL have parameters KP_TRK/KI_TRK, defaults 2/1, tracking gains.
REQ-007 SHALL have parameter LOCK_THRESH, default 2, maximum error magnitude counted as in-lock.
REQ-008 SHALL have parameter LOCK_CYCLES, default 64, consecutive in-lock cycles required to declare lock.
REQ-009 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles spent in any wait state.
REQ-010 SHALL have ports: fpga_clk_i  in  1  sole clock, all logic on its rising edge.
REQ-011 SHALL have ports: reset_i  in  1  reset, synchronous and active-high.
REQ-012 SHALL have ports: start_i  in  1  begin bring-up (level, sampled each cycle).
REQ-013 SHALL have ports: abort_i  in  1  return to IDLE.
REQ-014 SHALL have ports: error_i  in  NODES*PDET_WIDTH  node n error at bits [n*PDET_WIDTH +: PDET_WIDTH].
REQ-015 SHALL have ports: enable_o  out  NODES  per-node ADPLL enable.
REQ-016 SHALL have ports: network_mode_o  out  1  0 = nodes track common reference, 1 = network references.
REQ-017 SHALL have ports: kp_o  out  KP_WIDTH; ki_o  out  KI_WIDTH  loop-filter gains.
REQ-018 SHALL have ports: locked_o  out  NODES  per-node lock flags.
REQ-019 SHALL have ports: state_o  out  3  current state code; done_o  out  1; timeout_o  out  1.

Function
REQ-020 States and codes: IDLE=0, ACQUIRE=1, TRACK=2, NETWORK=3, RUN=4, FAULT=5; codes 6-7 unreachable, recover to IDLE next cycle.
REQ-021 IDLE: enable_o=0, network_mode_o=0, kp_o=ki_o=0; start_i=1 -> ACQUIRE next cycle.
REQ-022 ACQUIRE: enable_o all 1, network_mode_o=0, gains KP_ACQ/KI_ACQ; all locked_o=1 -> TRACK.
REQ-023 TRACK: enable_o all 1, network_mode_o=0, gains KP_TRK/KI_TRK; all locked_o=1 -> NETWORK.
REQ-024 NETWORK: enable_o all 1, network_mode_o=1, gains KP_TRK/KI_TRK; all locked_o=1 -> RUN.
REQ-025 RUN: outputs as NETWORK, done_o=1; done_o=0 in every other state.
REQ-026 Outputs are registered; state_o, gains, enables change on the same edge as the state register.
REQ-027 Per node: magnitude = |error| with most-negative value treated as 2^(PDET_WIDTH-1); in-lock when magnitude <= LOCK_THRESH.
REQ-028 Per-node lock counter increments each in-lock cycle, saturates at LOCK_CYCLES, clears to 0 on any out-of-lock cycle; locked_o[n]=1 iff counter==LOCK_CYCLES.
REQ-029 Lock counters and locked_o clear on every state entry (gear shift and mode change invalidate prior lock) and whenever enable_o[n]=0.
REQ-030 Timeout counter clears on state entry; in ACQUIRE/TRACK/NETWORK reaching TIMEOUT_CYCLES without transition -> FAULT.
REQ-031 FAULT: enable_o=0, gains 0, timeout_o=1 (held until FAULT exit); start_i=1 -> ACQUIRE with timeout_o cleared.
REQ-032 start_i ignored in ACQUIRE..RUN; abort_i=1 -> IDLE from any state; abort_i and start_i simultaneous: abort wins.
REQ-033 Lock completing on the same cycle as timeout expiry: lock transition wins.

Reset
REQ-034 reset_i=1 at a clock edge forces IDLE, all counters 0, all outputs 0, regardless of state or in-progress sequence; priority over abort_i/start_i.

Configuration
REQ-035 Macro SEQ_RELOCK_EN: when defined, any locked_o bit falling in RUN -> ACQUIRE (full re-acquisition with acquisition gains); when undefined, RUN is held, locked_o still updates, done_o stays 1 until abort_i/reset_i.

Verification
REQ-036 Defaults, all errors 0, start_i pulse -> state 1,2,3,4 with 64+1 cycles per wait state, done_o=1 at cycle ~196.
REQ-037 Node 2 error = 5'b11101 (-3) in ACQUIRE -> no transition; after 4096 cycles state_o=5, timeout_o=1, enable_o=0.
REQ-038 Error = 5'b10000 on node 0 -> magnitude 16, node 0 counter held 0; error 5'b11110 (-2) -> counts as in-lock.
REQ-039 In TRACK at lock cycle 40, one cycle node 1 error=3 -> node 1 counter restarts, TRACK extended by 41 cycles.
REQ-040 In RUN, node 3 error=7 for one cycle -> with SEQ_RELOCK_EN state_o=1, kp_o=8; without, state_o=4, locked_o=4'b0111.
REQ-041 reset_i and abort_i asserted mid-NETWORK, plus start_i+abort_i together in IDLE -> state_o=0, all outputs 0, no start.
